// File: rtl/sweep_pkg.sv
// rtl/sweep_pkg.sv - sweeper state enum, N_IN limits and hold-counter width helper
package sweep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int N_IN_MIN = 1;
  localparam int N_IN_MAX = 16;

  // Width of a counter that runs 0..hold-1, never narrower than one bit.
  function automatic int hold_cnt_w(input int hold);
    return (hold <= 2) ? 1 : $clog2(hold);
  endfunction

endpackage

// File: rtl/sweep_bin2gray.sv
// rtl/sweep_bin2gray.sv - combinational binary index to Gray-code vector map
module sweep_bin2gray #(
  parameter int W = 4
) (
  input  logic [W-1:0] bin,
  output logic [W-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - exhaustive truth-table sweeper with error count and first-failure capture
// SWEEP_GRAY_EN: when defined, vectors are applied in Gray order instead of binary order.
module truth_table_sweeper
  import sweep_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_OUT = 1,
  parameter int HOLD  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [N_IN-1:0]  vec_out,
  input  logic [N_OUT-1:0] dut_o,
  input  logic [N_OUT-1:0] exp_o,
  output logic             busy,
  output logic             done,
  output logic [N_IN:0]    err_cnt,
  output logic             first_err_valid,
  output logic [N_IN-1:0]  first_err_vec
);

  localparam int            HW        = hold_cnt_w(HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
  localparam logic [N_IN:0] IDX_LAST  = {1'b0, {N_IN{1'b1}}};

  generate
    if (N_IN < N_IN_MIN || N_IN > N_IN_MAX || HOLD < 1) begin : g_bad_cfg
      $error("truth_table_sweeper: unsupported N_IN or HOLD");
    end
  endgenerate

  state_t          state;
  state_t          state_n;
  logic [N_IN:0]   idx;
  logic [N_IN:0]   idx_n;
  logic [HW-1:0]   hold_cnt;
  logic [HW-1:0]   hold_n;
  logic [N_IN:0]   err_n;
  logic            fev_n;
  logic [N_IN-1:0] fvec_n;
  logic [N_IN-1:0] vec_map;
  logic            mismatch;

`ifdef SWEEP_GRAY_EN
  sweep_bin2gray #(.W(N_IN)) u_bin2gray (
    .bin  (idx[N_IN-1:0]),
    .gray (vec_map)
  );
`else
  assign vec_map = idx[N_IN-1:0];
`endif

  assign mismatch = (dut_o != exp_o);
  assign vec_out  = vec_map;
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      idx             <= '0;
      hold_cnt        <= '0;
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
    end else begin
      state           <= state_n;
      idx             <= idx_n;
      hold_cnt        <= hold_n;
      err_cnt         <= err_n;
      first_err_valid <= fev_n;
      first_err_vec   <= fvec_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    hold_n  = hold_cnt;
    err_n   = err_cnt;
    fev_n   = first_err_valid;
    fvec_n  = first_err_vec;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = RUN;
          idx_n   = '0;
          hold_n  = '0;
          err_n   = '0;
          fev_n   = 1'b0;
          fvec_n  = '0;
        end
      end
      RUN: begin
        // Compare only in the last hold cycle so the DUT gets HOLD-1 cycles to settle.
        if (hold_cnt == HOLD_LAST) begin
          if (mismatch) begin
            err_n = err_cnt + 1'b1;
            if (!first_err_valid) begin
              fev_n  = 1'b1;
              fvec_n = vec_map;
            end
          end
          if (idx == IDX_LAST) begin
            state_n = DONE;
          end else begin
            idx_n  = idx + 1'b1;
            hold_n = '0;
          end
        end else begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - self-checking bench for truth_table_sweeper (HOLD=1 and HOLD=3 instances)
module tb_truth_table_sweeper;

  localparam int N  = 4;
  localparam int NV = 1 << N;
  localparam int NI = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start   [NI];
  logic [N-1:0] vec     [NI];
  logic [0:0]   dut_o   [NI];
  logic [0:0]   exp_o   [NI];
  logic         busy    [NI];
  logic         done    [NI];
  logic [N:0]   err_cnt [NI];
  logic         fev     [NI];
  logic [N-1:0] fvec    [NI];

  int mode   [NI];
  int mmode  [NI];
  int mstate [NI];
  int k      [NI];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    truth_table_sweeper #(.N_IN(N), .N_OUT(1), .HOLD(g == 0 ? 1 : 3)) u_dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start[g]),
      .vec_out         (vec[g]),
      .dut_o           (dut_o[g]),
      .exp_o           (exp_o[g]),
      .busy            (busy[g]),
      .done            (done[g]),
      .err_cnt         (err_cnt[g]),
      .first_err_valid (fev[g]),
      .first_err_vec   (fvec[g])
    );
  end

  function automatic int hold_of(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  function automatic int map(input int i);
`ifdef SWEEP_GRAY_EN
    return i ^ (i >> 1);
`else
    return i;
`endif
  endfunction

  // Fault scenarios: which (vector value, cycle within the vector) disagree with the golden model.
  function automatic bit faulty(input int m, input int v, input int phase);
    case (m)
      1:       return v == 5;
      2:       return 1'b1;
      3:       return phase < 2;
      4:       return v == 6;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int exp_errs(input int m, input int h, input int upto);
    int c;
    c = 0;
    for (int i = 0; i < upto; i++) if (faulty(m, map(i), h - 1)) c++;
    return c;
  endfunction

  function automatic int exp_first(input int m, input int h, input int upto);
    for (int i = 0; i < upto; i++) if (faulty(m, map(i), h - 1)) return map(i);
    return 0;
  endfunction

  always_comb begin
    for (int g = 0; g < NI; g++) begin
      dut_o[g] = ^vec[g];
      exp_o[g] = (^vec[g]) ^ faulty(mode[g], int'(vec[g]), k[g] % hold_of(g));
    end
  end

  // Schedule model: 0 idle, 1 sweeping (k = cycles since accept), 2 finished.
  always @(posedge clk or posedge rst) begin
    for (int g = 0; g < NI; g++) begin
      if (rst) begin
        mstate[g] <= 0;
        k[g]      <= 0;
        mmode[g]  <= 0;
      end else if (mstate[g] != 1) begin
        if (start[g]) begin
          mstate[g] <= 1;
          k[g]      <= 0;
          mmode[g]  <= mode[g];
        end
      end else if (k[g] == NV * hold_of(g) - 1) begin
        mstate[g] <= 2;
      end else begin
        k[g] <= k[g] + 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int g = 0; g < NI; g++) begin : cmp
        int h, upto, ev;
        h    = hold_of(g);
        upto = (mstate[g] == 1) ? k[g] / h : (mstate[g] == 2) ? NV : 0;
        ev   = (mstate[g] == 2) ? map(NV - 1) : map(upto);
        chk("vec_out", int'(vec[g]), ev);
        chk("busy", int'(busy[g]), int'(mstate[g] == 1));
        chk("done", int'(done[g]), int'(mstate[g] == 2));
        chk("err_cnt", int'(err_cnt[g]), exp_errs(mmode[g], h, upto));
        chk("first_err_valid", int'(fev[g]), int'(exp_errs(mmode[g], h, upto) > 0));
        chk("first_err_vec", int'(fvec[g]), exp_first(mmode[g], h, upto));
      end
    end
  end

  task automatic sweep(input int g, input int m, output int lat);
    @(negedge clk);
    #1;
    mode[g]  = m;
    start[g] = 1'b1;
    @(posedge clk);
    #1 start[g] = 1'b0;
    lat = 0;
    while (!done[g] && lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
    end
  endtask

  initial begin
    int lat;
    int n;
    int ord [4];
`ifdef SWEEP_GRAY_EN
    ord = '{0, 1, 3, 2};
`else
    ord = '{0, 1, 2, 3};
`endif
    rst   = 1'b1;
    start = '{default: 1'b0};
    mode  = '{default: 0};
    repeat (2) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      chk("rst_vec", int'(vec[g]), 0);
      chk("rst_busy", int'(busy[g]), 0);
      chk("rst_done", int'(done[g]), 0);
      chk("rst_err", int'(err_cnt[g]), 0);
    end
    #1 rst = 1'b0;

    sweep(0, 0, lat);
    chk("lat_hold1", lat, 16);
    chk("clean_err", int'(err_cnt[0]), 0);
    chk("clean_fev", int'(fev[0]), 0);

    sweep(0, 1, lat);
    chk("v5_err", int'(err_cnt[0]), 1);
    chk("v5_fev", int'(fev[0]), 1);
    chk("v5_fvec", int'(fvec[0]), 5);

    sweep(0, 2, lat);
    chk("all_err", int'(err_cnt[0]), 16);
    chk("all_fvec", int'(fvec[0]), 0);

    sweep(1, 3, lat);
    chk("lat_hold3", lat, 48);
    chk("settle_err", int'(err_cnt[1]), 0);

    sweep(1, 1, lat);
    chk("h3_v5_err", int'(err_cnt[1]), 1);
    chk("h3_v5_fvec", int'(fvec[1]), 5);

    sweep(0, 4, lat);
    chk("v6_fvec", int'(fvec[0]), 6);

    // Order of the first vectors, then reset in the middle of the sweep.
    @(negedge clk);
    #1 mode[0] = 0;
    start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("order", int'(vec[0]), ord[j]);
    end
    n = 0;
    while (vec[0] != 4'd9 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("reach_v9", int'(vec[0]), 9);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_vec", int'(vec[0]), 0);
    chk("mid_rst_busy", int'(busy[0]), 0);
    chk("mid_rst_err", int'(err_cnt[0]), 0);
    @(negedge clk);
    #1 rst = 1'b0;

    // Fresh sweep with a stray start pulse while running.
    @(negedge clk);
    #1 mode[0] = 1;
    start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1 start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    n = 0;
    while (!done[0] && n < 60) begin
      @(posedge clk);
      n++;
      #1;
    end
    chk("stray_err", int'(err_cnt[0]), 1);
    chk("stray_fvec", int'(fvec[0]), 5);

    // start held high across DONE: one DONE cycle, then a new sweep.
    @(negedge clk);
    #1 mode[0] = 2;
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    n = 0;
    while (!done[0] && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_done1", int'(done[0]), 1);
    @(negedge clk);
    chk("b2b_restart", int'(busy[0]), 1);
    n = 0;
    while (!done[0] && n < 60) begin
      @(negedge clk);
      n++;
    end
    #1 start[0] = 1'b0;
    chk("b2b_err", int'(err_cnt[0]), 16);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
